// File: rtl/frame_dump_ctrl.sv
// frame_dump_ctrl
//
// Streams a downsampled video frame from the downsample buffer to the
// debug UART. After a start request it waits for the next frame boundary,
// sends a 3-byte sync header (HDR0, HDR1, frame_count), then reads the
// buffer word by word and sends each word MSB byte first. A holdoff counter
// spaces the bytes so the host can keep in sync.
//
// Ports:
//   clk12        system clock (12 MHz)
//   areset_n     asynchronous active-low reset
//   start        dump request, honoured only when idle
//   abort        cancels a dump in progress
//   frame_done   one-cycle pulse marking a completed buffer frame
//   read_x       buffer column address (0..COLS-1)
//   read_y       buffer row address (0..ROWS-1)
//   read_data    buffer word, valid READ_LATENCY cycles after an address change
//   uart_busy    UART is transmitting
//   uart_write   one-cycle byte strobe to the UART
//   uart_data    byte to send, held until the next strobe
//   busy         high whenever a dump is armed or in progress
//   frame_count  number of completed dumps, wraps 255 -> 0
module frame_dump_ctrl #(
  parameter int         COLS         = 40,
  parameter int         ROWS         = 30,
  parameter int         HOLDOFF_BITS = 13,
  parameter int         READ_LATENCY = 1,
  parameter logic [7:0] HDR0         = 8'hA5,
  parameter logic [7:0] HDR1         = 8'h5A
) (
  input  logic        clk12,
  input  logic        areset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        frame_done,
  output logic [5:0]  read_x,
  output logic [4:0]  read_y,
  input  logic [31:0] read_data,
  input  logic        uart_busy,
  output logic        uart_write,
  output logic [7:0]  uart_data,
  output logic        busy,
  output logic [7:0]  frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_HDR,
    S_FETCH,
    S_SEND
  } state_t;

  localparam logic [5:0] LAST_X   = 6'(COLS - 1);
  localparam logic [4:0] LAST_Y   = 5'(ROWS - 1);
  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);
  localparam logic [HOLDOFF_BITS-1:0] HOLDOFF_ONE = HOLDOFF_BITS'(1);

  state_t                  state_reg, state_next;
  logic [5:0]              x_reg, x_next;
  logic [4:0]              y_reg, y_next;
  logic [1:0]              z_reg, z_next;        // byte index within the word
  logic [1:0]              h_reg, h_next;        // header byte index
  logic [1:0]              lat_reg, lat_next;    // read latency wait counter
  logic [31:0]             word_reg, word_next;
  logic [HOLDOFF_BITS-1:0] holdoff_reg, holdoff_next;
  logic                    uart_write_reg, uart_write_next;
  logic [7:0]              uart_data_reg, uart_data_next;
  logic                    busy_reg, busy_next;
  logic [7:0]              frame_count_reg, frame_count_next;

  logic                    holdoff_sat;
  logic                    send_ok;
  logic [7:0]              hdr_byte;
  logic [7:0]              word_byte;

  assign holdoff_sat = &holdoff_reg;
  // A byte may only go out once the line has been quiet long enough, the
  // UART is free and no strobe is already on the wire this cycle.
  assign send_ok     = holdoff_sat && !uart_busy && !uart_write_reg;

  always_comb begin
    hdr_byte = frame_count_reg;
    case (h_reg)
      2'd0:    hdr_byte = HDR0;
      2'd1:    hdr_byte = HDR1;
      default: hdr_byte = frame_count_reg;
    endcase
  end

  always_comb begin
    word_byte = word_reg[7:0];
    case (z_reg)
      2'd0:    word_byte = word_reg[31:24];
      2'd1:    word_byte = word_reg[23:16];
      2'd2:    word_byte = word_reg[15:8];
      default: word_byte = word_reg[7:0];
    endcase
  end

  always_ff @(posedge clk12 or negedge areset_n) begin
    if (!areset_n) begin
      state_reg       <= S_IDLE;
      x_reg           <= '0;
      y_reg           <= '0;
      z_reg           <= '0;
      h_reg           <= '0;
      lat_reg         <= '0;
      word_reg        <= '0;
      holdoff_reg     <= '0;
      uart_write_reg  <= 1'b0;
      uart_data_reg   <= '0;
      busy_reg        <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      z_reg           <= z_next;
      h_reg           <= h_next;
      lat_reg         <= lat_next;
      word_reg        <= word_next;
      holdoff_reg     <= holdoff_next;
      uart_write_reg  <= uart_write_next;
      uart_data_reg   <= uart_data_next;
      busy_reg        <= busy_next;
      frame_count_reg <= frame_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    x_next           = x_reg;
    y_next           = y_reg;
    z_next           = z_reg;
    h_next           = h_reg;
    lat_next         = lat_reg;
    word_next        = word_reg;
    uart_write_next  = 1'b0;
    uart_data_next   = uart_data_reg;
    frame_count_next = frame_count_reg;

    // Holdoff restarts whenever the UART is busy or a strobe is out, so the
    // quiet gap is measured from the end of the previous byte.
    if (uart_busy || uart_write_reg) begin
      holdoff_next = '0;
    end else if (!holdoff_sat) begin
      holdoff_next = holdoff_reg + HOLDOFF_ONE;
    end else begin
      holdoff_next = holdoff_reg;
    end

    case (state_reg)
      S_IDLE: begin
        x_next = '0;
        y_next = '0;
        z_next = '0;
        h_next = '0;
        if (start && !abort) begin
          state_next = S_ARM;
        end
      end

      S_ARM: begin
        if (frame_done) begin
          h_next     = '0;
          state_next = S_HDR;
        end
      end

      S_HDR: begin
        if (send_ok) begin
          uart_write_next = 1'b1;
          uart_data_next  = hdr_byte;
          if (h_reg == 2'd2) begin
            lat_next   = '0;
            state_next = S_FETCH;
          end else begin
            h_next = h_reg + 2'd1;
          end
        end
      end

      S_FETCH: begin
        if (lat_reg == LAT_LAST) begin
          word_next  = read_data;
          z_next     = '0;
          state_next = S_SEND;
        end else begin
          lat_next = lat_reg + 2'd1;
        end
      end

      S_SEND: begin
        if (send_ok) begin
          uart_write_next = 1'b1;
          uart_data_next  = word_byte;
          if (z_reg == 2'd3) begin
            lat_next = '0;
            if (x_reg == LAST_X && y_reg == LAST_Y) begin
              frame_count_next = frame_count_reg + 8'd1;
              x_next           = '0;
              y_next           = '0;
              state_next       = S_IDLE;
            end else if (x_reg == LAST_X) begin
              x_next     = '0;
              y_next     = y_reg + 5'd1;
              state_next = S_FETCH;
            end else begin
              x_next     = x_reg + 6'd1;
              state_next = S_FETCH;
            end
          end else begin
            z_next = z_reg + 2'd1;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort overrides everything decided above: no new strobe, no count
    // update, addresses back to the origin.
    if (abort && state_reg != S_IDLE) begin
      state_next       = S_IDLE;
      uart_write_next  = 1'b0;
      uart_data_next   = uart_data_reg;
      frame_count_next = frame_count_reg;
      x_next           = '0;
      y_next           = '0;
      z_next           = '0;
      h_next           = '0;
    end

    busy_next = (state_next != S_IDLE);
  end

  assign read_x      = x_reg;
  assign read_y      = y_reg;
  assign uart_write  = uart_write_reg;
  assign uart_data   = uart_data_reg;
  assign busy        = busy_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Testbench for frame_dump_ctrl: small 2x2 buffer, short holdoff, UART model
// that stays busy for busy_len cycles after each strobe. Expected bytes are
// queued when a dump is requested and checked as strobes appear.
module tb_frame_dump_ctrl;

  localparam int COLS = 2;
  localparam int ROWS = 2;
  localparam int HB   = 3;
  localparam int RL   = 1;

  logic        clk12 = 1'b0;
  logic        areset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        frame_done = 1'b0;
  logic [5:0]  read_x;
  logic [4:0]  read_y;
  logic [31:0] read_data;
  logic        uart_busy;
  logic        uart_write;
  logic [7:0]  uart_data;
  logic        busy;
  logic [7:0]  frame_count;

  frame_dump_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .HOLDOFF_BITS(HB), .READ_LATENCY(RL),
    .HDR0(8'hA5), .HDR1(8'h5A)
  ) dut (
    .clk12(clk12), .areset_n(areset_n), .start(start), .abort(abort),
    .frame_done(frame_done), .read_x(read_x), .read_y(read_y),
    .read_data(read_data), .uart_busy(uart_busy), .uart_write(uart_write),
    .uart_data(uart_data), .busy(busy), .frame_count(frame_count)
  );

  always #5 clk12 = ~clk12;

  // Buffer model: word = {y, x, C0, 11}
  assign read_data = {3'b000, read_y, 2'b00, read_x, 8'hC0, 8'h11};

  // UART model
  int busy_len = 10;
  int busy_cnt = 0;
  always @(posedge clk12) begin
    if (uart_write) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_busy = (busy_cnt > 0);

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_fc = 8'h00;
  int cyc = 0;
  int strobe_count = 0;
  int last_strobe = -1;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  always @(posedge clk12) cyc <= cyc + 1;

  // Strobe monitor / scoreboard
  always @(negedge clk12) begin
    if (uart_write) begin
      strobe_count++;
      check_value("write_while_busy", 32'(uart_busy), 32'd0);
      if (last_strobe >= 0)
        check_value("strobe_gap", 32'((cyc - last_strobe) >= busy_len + 7), 32'd1);
      last_strobe = cyc;
      if (exp_q.size() > 0) check_value("uart_byte", 32'(uart_data), 32'(exp_q.pop_front()));
      else check_value("spurious_strobe", 32'(uart_write), 32'd0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk12);
  endtask

  task automatic push_dump();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(exp_fc);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        exp_q.push_back(8'(y));
        exp_q.push_back(8'(x));
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'h11);
      end
  endtask

  task automatic wait_dump_done(input int limit, input bit noise);
    int k = 0;
    forever begin
      @(negedge clk12);
      #1;
      k++;
      start = (noise && k == 40);
      if (exp_q.size() == 0 && !busy) break;
      if (k >= limit) break;
    end
    start = 1'b0;
    check_value("dump_in_time", 32'(k < limit), 32'd1);
  endtask

  task automatic wait_strobes(input int target);
    int k = 0;
    while (strobe_count < target && k < 2000) begin
      @(negedge clk12);
      #1;
      k++;
    end
    check_value("strobe_wait_in_time", 32'(strobe_count >= target), 32'd1);
  endtask

  task automatic pulse_start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(2);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic run_dump(input bit noise);
    int base;
    base = strobe_count;
    push_dump();
    pulse_start_frame();
    wait_dump_done(3000, noise);
    exp_fc = exp_fc + 8'd1;
    check_value("strobes_per_dump", 32'(strobe_count - base), 32'd19);
    check_value("frame_count", 32'(frame_count), 32'(exp_fc));
    check_value("busy_after_dump", 32'(busy), 32'd0);
    tick(3);
    check_value("busy_stays_low", 32'(busy), 32'd0);
    $display("dump done: frame_count=%0d strobes=%0d", frame_count, strobe_count - base);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // Reset state
    tick(3);
    check_value("rst_read_x", 32'(read_x), 32'd0);
    check_value("rst_read_y", 32'(read_y), 32'd0);
    check_value("rst_uart_write", 32'(uart_write), 32'd0);
    check_value("rst_uart_data", 32'(uart_data), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_frame_count", 32'(frame_count), 32'd0);
    areset_n = 1'b1;
    tick(2);

    // Basic dump
    run_dump(1'b0);

    // Arm wait: a frame_done while idle is not remembered
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tick(3);
    check_value("idle_frame_done_ignored", 32'(busy), 32'd0);
    base = strobe_count;
    push_dump();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(500);
    check_value("arm_no_strobes", 32'(strobe_count - base), 32'd0);
    check_value("arm_busy", 32'(busy), 32'd1);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    wait_dump_done(3000, 1'b0);
    exp_fc = exp_fc + 8'd1;
    check_value("arm_strobes", 32'(strobe_count - base), 32'd19);
    check_value("arm_frame_count", 32'(frame_count), 32'(exp_fc));
    $display("arm-wait dump done: frame_count=%0d", frame_count);

    // Abort after the 7th strobe
    base = strobe_count;
    push_dump();
    pulse_start_frame();
    wait_strobes(base + 7);
    abort = 1'b1;
    exp_q.delete();
    tick();
    abort = 1'b0;
    check_value("abort_busy", 32'(busy), 32'd0);
    check_value("abort_read_x", 32'(read_x), 32'd0);
    check_value("abort_read_y", 32'(read_y), 32'd0);
    check_value("abort_frame_count", 32'(frame_count), 32'(exp_fc));
    tick(300);
    check_value("abort_no_more_strobes", 32'(strobe_count - base), 32'd7);
    $display("abort done: strobes=%0d", strobe_count - base);

    // Asynchronous reset in the middle of a dump
    base = strobe_count;
    push_dump();
    pulse_start_frame();
    wait_strobes(base + 6);
    @(posedge clk12);
    #3;
    areset_n = 1'b0;
    #1;
    check_value("arst_uart_write", 32'(uart_write), 32'd0);
    check_value("arst_uart_data", 32'(uart_data), 32'd0);
    check_value("arst_busy", 32'(busy), 32'd0);
    check_value("arst_frame_count", 32'(frame_count), 32'd0);
    check_value("arst_read_x", 32'(read_x), 32'd0);
    check_value("arst_read_y", 32'(read_y), 32'd0);
    exp_q.delete();
    exp_fc = 8'h00;
    tick();
    areset_n = 1'b1;
    tick(2);
    $display("async reset applied mid-dump");

    // 256 dumps: header byte walks 00..FF, frame_count wraps; start pulses
    // during the first few dumps must be ignored. Shorter UART busy keeps
    // the run brief.
    busy_len = 1;
    for (int i = 0; i < 256; i++) run_dump(i < 4);
    check_value("wrap_frame_count", 32'(frame_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
